// File: rtl/enc_stamp_pkg.sv
// Shared definitions for the encoder edge stamper: event word layout and
// the quadrature transition decode table.
package enc_stamp_pkg;

    localparam int EVT_W    = 128;
    localparam int TS_LSB   = 0;
    localparam int TS_W     = 64;
    localparam int POS_LSB  = 64;
    localparam int POS_W    = 32;
    localparam int DIR_BIT  = 96;
    localparam int STEP_BIT = 97;
    localparam int Z_BIT    = 98;
    localparam int ERR_BIT  = 99;
    localparam int OVF_BIT  = 100;

    typedef enum logic [1:0] {
        Q_NONE = 2'd0,
        Q_INC  = 2'd1,
        Q_DEC  = 2'd2,
        Q_ILL  = 2'd3
    } quad_e;

    // 2-bit code per {prev_ab, cur_ab} index; forward order is 00->10->11->01.
    localparam logic [31:0] QUAD_LUT = 32'h274E_B1D8;

    function automatic quad_e quad_decode(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [3:0] idx;
        idx = {prev_ab, cur_ab};
        return quad_e'(QUAD_LUT[{idx, 1'b0} +: 2]);
    endfunction

endpackage

// File: rtl/enc_evt_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted
// only when a pop happens in the same cycle.
module enc_evt_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             wr_en, rd_en;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign wr_en   = push_i & (~full_o | pop_i);
    assign rd_en   = pop_i & ~empty_o;
    assign wr_d    = wr_q + {{AW{1'b0}}, wr_en};
    assign rd_d    = rd_q + {{AW{1'b0}}, rd_en};
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/enc_edge_stamper.sv
// Quadrature encoder decoder that stamps every A/B/Z edge with the live
// timestamp and position, queueing events onto an AXI-Stream master.
module enc_edge_stamper
    import enc_stamp_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int Z_RESET_POS = 1,
    parameter int DROP_CNT_W  = 16
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic [63:0]           counter_in,
    input  logic                  enc_a,
    input  logic                  enc_b,
    input  logic                  enc_z,
    input  logic                  enable,
    input  logic                  clear,
    output logic [EVT_W-1:0]      m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic signed [31:0]    position,
    output logic [DROP_CNT_W-1:0] drop_count
);

    // Bit order in the synchroniser vectors is {a, b, z}.
    logic [2:0]              s1_q, s2_q, s3_q;
    logic signed [31:0]      pos_q, pos_d, pos_evt;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;
    logic                    ovf_q, ovf_d;
    logic                    vld_p1_q;
    logic [EVT_W-1:0]        evt_d, evt_p1_q;
    logic [EVT_W-1:0]        fifo_wdata, fifo_rdata;
    logic                    step_det, z_det, evt_det;
    logic                    fifo_full, fifo_empty, pop, accept, drop;
    quad_e                   code;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        code     = quad_decode(s3_q[2:1], s2_q[2:1]);
        step_det = enable & (s2_q[2:1] != s3_q[2:1]);
        z_det    = enable & s2_q[0] & ~s3_q[0];
        evt_det  = step_det | z_det;

        pos_evt = pos_q;
        if (step_det && code == Q_INC) begin
            pos_evt = pos_q + 32'sd1;
        end else if (step_det && code == Q_DEC) begin
            pos_evt = pos_q - 32'sd1;
        end

        // The event keeps pos_evt; clear and index reset only affect the live counter.
        pos_d = pos_evt;
        if (clear || (z_det && Z_RESET_POS != 0)) begin
            pos_d = '0;
        end

        evt_d                       = '0;
        evt_d[TS_LSB +: TS_W]       = counter_in;
        evt_d[POS_LSB +: POS_W]     = pos_evt;
        evt_d[DIR_BIT]              = step_det & (code == Q_INC);
        evt_d[STEP_BIT]             = step_det;
        evt_d[Z_BIT]                = z_det;
        evt_d[ERR_BIT]              = step_det & (code == Q_ILL);
    end

    // Stage p1: captured event is offered to the FIFO, carrying the sticky overflow.
    always_comb begin
        pop                 = m_axis_tvalid & m_axis_tready;
        accept              = vld_p1_q & (~fifo_full | pop);
        drop                = vld_p1_q & ~accept;
        fifo_wdata          = evt_p1_q;
        fifo_wdata[OVF_BIT] = ovf_q;

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (accept) begin
            ovf_d = 1'b0;
        end

        drop_d = drop_q;
        if (clear) begin
            drop_d = '0;
        end else if (drop) begin
            drop_d = sat_inc(drop_q);
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            pos_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            vld_p1_q <= 1'b0;
        end else begin
            s1_q     <= {enc_a, enc_b, enc_z};
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            pos_q    <= pos_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            vld_p1_q <= evt_det;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        evt_p1_q <= evt_d;
    end

    enc_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (s_axi_aclk),
        .rst_i   (s_axi_areset),
        .push_i  (vld_p1_q),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_rdata;
    assign position      = pos_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_enc_edge_stamper.sv
// Directed bench for enc_edge_stamper: vector table plus multi-cycle sequences.
module tb_enc_edge_stamper;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  cyc = 64'd0;
    logic         enc_a, enc_b, enc_z, enable, clear, tready;
    logic [127:0] tdata;
    logic         tvalid;
    logic [31:0]  position;
    logic [15:0]  drop_count;

    int           nchk = 0;
    int           nfail = 0;
    logic [63:0]  exp_ts;
    int           gidx;
    logic [31:0]  mpos;
    logic [1:0]   gray [4];
    logic [127:0] got_q [$];
    logic [127:0] exp_w [$];

    typedef struct {
        logic        a, b, z;
        logic [31:0] pos;
        logic        dir, step, zf, err;
    } vec_t;
    vec_t vecs [11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 64'd1;

    enc_edge_stamper #(
        .FIFO_DEPTH  (16),
        .Z_RESET_POS (1),
        .DROP_CNT_W  (16)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (rst),
        .counter_in    (cyc),
        .enc_a         (enc_a),
        .enc_b         (enc_b),
        .enc_z         (enc_z),
        .enable        (enable),
        .clear         (clear),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .position      (position),
        .drop_count    (drop_count)
    );

    always @(negedge clk) begin
        if (!rst && tvalid && tready) got_q.push_back(tdata);
    end

    function automatic logic [127:0] mk_evt(input logic [63:0] ts, input logic [31:0] pos,
                                            input logic dir, step, z, err, ovf);
        logic [127:0] w;
        w         = '0;
        w[63:0]   = ts;
        w[95:64]  = pos;
        w[96]     = dir;
        w[97]     = step;
        w[98]     = z;
        w[99]     = err;
        w[100]    = ovf;
        return w;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_evt(input string name, input logic [127:0] exp);
        if (got_q.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL %s: no event received, expected %h", name, exp);
        end else begin
            chk(name, got_q.pop_front(), exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic b, input logic z);
        @(posedge clk);
        #1;
        enc_a  = a;
        enc_b  = b;
        enc_z  = z;
        exp_ts = cyc + 64'd2;
    endtask

    task automatic step_fwd();
        gidx = (gidx + 1) % 4;
        drive(gray[gidx][1], gray[gidx][0], 1'b0);
        mpos = mpos + 32'd1;
    endtask

    initial begin
        gray[0] = 2'b00; gray[1] = 2'b10; gray[2] = 2'b11; gray[3] = 2'b01;
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'd3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'd1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
        enable = 1'b1; clear = 1'b0; tready = 1'b1;
        gidx = 0; mpos = 32'd0;
        wait_cyc(3);
        chk("reset_tvalid", {127'd0, tvalid}, 128'd0);
        chk("reset_tdata", tdata, 128'd0);
        chk("reset_position", {96'd0, position}, 128'd0);
        chk("reset_drop", {112'd0, drop_count}, 128'd0);
        rst = 1'b0;
        wait_cyc(2);

        // Forward, reverse, illegal jumps, and step+index with Z reset of the counter.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].z);
            wait_cyc(7);
            check_evt($sformatf("vec%0d_evt", i),
                      mk_evt(exp_ts, vecs[i].pos, vecs[i].dir, vecs[i].step, vecs[i].zf, vecs[i].err, 1'b0));
            chk($sformatf("vec%0d_pos", i), {96'd0, position}, vecs[i].zf ? 128'd0 : {96'd0, vecs[i].pos});
        end
        drive(1'b1, 1'b0, 1'b0);
        gidx = 1; mpos = 32'd0;
        wait_cyc(8);

        // Z with a +1 step at position 9.
        for (int i = 0; i < 9; i++) begin
            step_fwd();
            wait_cyc(1);
        end
        wait_cyc(8);
        got_q.delete();
        chk("z_setup_pos", {96'd0, position}, 128'd9);
        gidx = (gidx + 1) % 4;
        drive(gray[gidx][1], gray[gidx][0], 1'b1);
        wait_cyc(7);
        check_evt("z_step_evt", mk_evt(exp_ts, 32'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        chk("z_pos_cleared", {96'd0, position}, 128'd0);
        mpos = 32'd0;
        drive(gray[gidx][1], gray[gidx][0], 1'b0);
        wait_cyc(6);
        chk("z_fall_no_evt", got_q.size(), 128'd0);

        // Overflow: 19 steps into a 16-deep FIFO with the sink stalled.
        tready = 1'b0;
        for (int i = 0; i < 19; i++) begin
            step_fwd();
            if (i < 16) exp_w.push_back(mk_evt(exp_ts, mpos, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
            wait_cyc(1);
        end
        wait_cyc(8);
        chk("ovf_drop_count", {112'd0, drop_count}, 128'd3);
        chk("ovf_tvalid_held", {127'd0, tvalid}, 128'd1);
        chk("ovf_head_stable", tdata, exp_w[0]);
        tready = 1'b1;
        wait_cyc(24);
        chk("ovf_drain_count", got_q.size(), 128'd16);
        for (int i = 0; i < 16; i++) begin
            check_evt($sformatf("drain%0d", i), exp_w[i]);
        end
        step_fwd();
        wait_cyc(7);
        check_evt("ovf_flag_evt", mk_evt(exp_ts, 32'd20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        step_fwd();
        wait_cyc(7);
        check_evt("ovf_flag_cleared", mk_evt(exp_ts, 32'd21, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

        // Clear alone, then clear coinciding with a step at position 5.
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        chk("clear_pos", {96'd0, position}, 128'd0);
        chk("clear_drop", {112'd0, drop_count}, 128'd0);
        mpos = 32'd0;
        for (int i = 0; i < 5; i++) begin
            step_fwd();
            wait_cyc(1);
        end
        wait_cyc(8);
        got_q.delete();
        chk("clear_setup_pos", {96'd0, position}, 128'd5);
        step_fwd();
        wait_cyc(2);
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        chk("clear_step_pos", {96'd0, position}, 128'd0);
        wait_cyc(5);
        check_evt("clear_step_evt", mk_evt(exp_ts, 32'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        mpos = 32'd0;

        // Asynchronous reset while the stream holds valid data.
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_fwd();
            wait_cyc(1);
        end
        wait_cyc(6);
        chk("rst_pre_tvalid", {127'd0, tvalid}, 128'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_tvalid", {127'd0, tvalid}, 128'd0);
        chk("rst_async_tdata", tdata, 128'd0);
        enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
        gidx = 0; mpos = 32'd0;
        wait_cyc(2);
        rst = 1'b0;
        tready = 1'b1;
        wait_cyc(10);
        chk("rst_no_spurious", got_q.size(), 128'd0);
        chk("rst_post_tvalid", {127'd0, tvalid}, 128'd0);
        chk("rst_post_pos", {96'd0, position}, 128'd0);

        // Disabled step is ignored and not replayed on re-enable.
        enable = 1'b0;
        step_fwd();
        mpos = 32'd0;
        wait_cyc(7);
        chk("dis_pos", {96'd0, position}, 128'd0);
        chk("dis_no_evt", got_q.size(), 128'd0);
        enable = 1'b1;
        wait_cyc(6);
        chk("reen_no_stale", got_q.size(), 128'd0);
        step_fwd();
        wait_cyc(7);
        check_evt("reen_evt", mk_evt(exp_ts, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/enc_edge_stamper.md
Name: enc_edge_stamper

Overview:
- Consumes the free-running 64-bit timestamp produced by the AXI-lite timestamp counter, and sits directly downstream of it.
- Decodes a quadrature encoder (A/B/Z) and tags every decoded edge with the current timestamp and the signed position.
- Queues tagged events in an internal FIFO and presents them to the DMA/packer on an AXI-Stream master.
- Provides the time-resolved encoder record for the stimulator encoder readout.

Parameters:
- FIFO_DEPTH, 16, number of event entries; power of two, min 4.
- Z_RESET_POS, 1, if 1 a Z rising edge clears the position counter after the event is recorded.
- DROP_CNT_W, 16, width of the saturating dropped-event counter.

Ports:
- s_axi_aclk  in  1  sole clock; the timestamp domain.
- s_axi_areset  in  1  asynchronous, active-high reset.
- counter_in  in  64  timestamp from the upstream counter; sampled every cycle.
- enc_a  in  1  encoder A; asynchronous pin.
- enc_b  in  1  encoder B; asynchronous pin.
- enc_z  in  1  encoder index; asynchronous pin.
- enable  in  1  level; 0 suppresses event generation and position updates.
- clear  in  1  one-cycle pulse; zeroes position and drop count.
- m_axis_tdata  out  128  event word.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- position  out  32  live signed position.
- drop_count  out  DROP_CNT_W  saturating count of events lost to FIFO full.

Behaviour:
- Clock and reset: one clock, s_axi_aclk. s_axi_areset is asynchronous and active-high.
- Reset: clears all sync flops, position, drop_count, the sticky overflow flag and the FIFO. m_axis_tvalid=0, m_axis_tdata=0.
- Synchroniser: each of enc_a/enc_b/enc_z goes through a 2-FF synchroniser (s1, s2) plus a history flop s3 = previous s2. Synchroniser flops reset to 0.
- Step detect: a step is detected in the cycle where {a_s2,b_s2} != {a_s3,b_s3} and enable=1.
- Sequence 00->10->11->01->00 is +1. The reverse sequence is -1.
- Both bits changing at once is an illegal step: position unchanged, event still generated with err=1.
- Index detect: z_s2 & ~z_s3 & enable.
- Event capture: an event is generated in a cycle where a step and/or index is detected. Step and index in the same cycle produce ONE event carrying both flags.
- Timestamp field = counter_in sampled on that same clock edge.
- Position field = value after this step's update and before any Z clear.
- Event word layout:
  - [63:0] timestamp
  - [95:64] position (two's complement, wraps modulo 2^32)
  - [96] dir: 1 = +1, 0 otherwise
  - [97] step
  - [98] z
  - [99] err
  - [100] ovf: at least one event was dropped since the previous accepted event
  - [127:101] = 0
- Position update:
  - Applied on the event's clock edge.
  - When Z_RESET_POS=1 and z: position <= 0 after recording.
  - clear has priority over step and Z in the same cycle: position <= 0, and the event (if any) still reports the pre-clear update.
- FIFO: synchronous, first-word fall-through.
  - An event written at edge N yields m_axis_tvalid=1 after edge N+1 when the FIFO was empty.
  - A transfer pops when tvalid & tready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (push of an event when full and popping is accepted).
- FIFO full with no pop:
  - The event is discarded.
  - drop_count increments, saturating at all-ones.
  - The sticky ovf flag is set and is attached to the next accepted event, then cleared.
  - clear zeroes drop_count; ovf is unaffected.
- Stream rules:
  - tdata is stable while tvalid & ~tready.
  - tvalid never deasserts without a handshake except on reset.
- Enable and reset:
  - enable=0: history flops still track, so no burst of stale events occurs on re-enable.
  - Reset mid-stream drops all queued events immediately.

Decomposition:
- Package enc_stamp_pkg holds:
  - event field bit offsets (TS_LSB, POS_LSB, DIR_BIT, STEP_BIT, Z_BIT, ERR_BIT, OVF_BIT)
  - EVT_W=128
  - the quadrature direction lookup constant
- One sub-module: enc_evt_fifo, parameterised FWFT sync FIFO (width, depth) with full/empty/push/pop.

Test Plan:
- Reset, then drive AB 00->10->11->01->00 with counter_in = cycle count and tready=1 -> four events, positions 1,2,3,4, dir=1, and each timestamp = counter_in on the capture edge (pin change + 2 cycles).
- Reverse the sequence from position 4 -> positions 3,2,1,0, dir=0; then jump AB 00->11 -> one event with err=1, position 0.
- Z rising together with a +1 step at position 9, Z_RESET_POS=1 -> single event with step=1, z=1, position 10; live position then reads 0.
- Hold tready=0 and generate FIFO_DEPTH+3 steps -> FIFO_DEPTH events queued, drop_count=3. Then release tready and make one more step -> the queued events drain unchanged, followed by the new event with ovf=1.
- Pulse clear during an active step at position 5 -> event reports 6; position and drop_count read 0 next cycle.
- Assert s_axi_areset asynchronously mid-transfer with tvalid=1 -> tvalid falls without waiting for a clock edge; after release the FIFO is empty, position=0, and no spurious event appears.
